// File: rtl/apb_pkg.sv
// Shared state encoding and default sizing for the APB manager block.
package apb_pkg;

  localparam int unsigned APB_ADDR_WIDTH_DEFAULT     = 10;
  localparam int unsigned APB_DATA_WIDTH_DEFAULT     = 8;
  localparam int unsigned APB_TIMEOUT_CYCLES_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_manager_if.sv
// Command/response handshake plus APB bus signals of one APB manager.
// master = the manager itself, slave = the side feeding commands and acting as subordinate.
interface apb_manager_if
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = APB_ADDR_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = APB_DATA_WIDTH_DEFAULT
);

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  logic                  PSELx;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [DATA_WIDTH-1:0] PWDATA;
  logic [DATA_WIDTH-1:0] PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA
  );

endinterface

// File: rtl/apb_timeout_ctr.sv
// Counts ACCESS wait cycles; expired fires on the wait cycle that reaches LIMIT.
module apb_timeout_ctr #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic srst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count_reg;

  // count_reg holds the waits already seen, so the LIMIT-th wait is the expiring one
  assign expired = count_en && (count_reg == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk) begin
    if (srst || clear) begin
      count_reg <= '0;
    end else if (count_en && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/apb_manager.sv
// APB manager: turns valid/ready commands into APB SETUP/ACCESS transfers with a one-cycle response.
// Optional ACCESS-phase timeout is built only when APB_MGR_TIMEOUT_EN is defined.
module apb_manager
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = APB_ADDR_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH     = APB_DATA_WIDTH_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = APB_TIMEOUT_CYCLES_DEFAULT
) (
  input  logic             PCLK,
  input  logic             PRESET,
  apb_manager_if.master    bus
);

  apb_state_e            state_reg;
  apb_state_e            state_next;
  logic                  psel;
  logic                  penable;
  logic                  cmd_ready;
  logic                  handshake;
  logic                  complete;
  logic                  timeout_hit;

  logic                  pwrite_reg;
  logic [ADDR_WIDTH-1:0] paddr_reg;
  logic [DATA_WIDTH-1:0] pwdata_reg;
  logic                  rsp_valid_reg;
  logic [DATA_WIDTH-1:0] rsp_rdata_reg;
  logic                  rsp_err_reg;

  // A new command may be taken in IDLE or on the cycle the current ACCESS completes
  assign cmd_ready = !PRESET &&
                     ((state_reg == IDLE) || ((state_reg == ACCESS) && bus.PREADY));
  assign handshake = bus.cmd_valid && cmd_ready;
  assign complete  = (state_reg == ACCESS) && bus.PREADY;

`ifdef APB_MGR_TIMEOUT_EN
  apb_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (PCLK),
    .srst    (PRESET),
    .clear   (state_reg == SETUP),
    .count_en((state_reg == ACCESS) && !bus.PREADY),
    .expired (timeout_hit)
  );
`else
  // Parameter stays in the list so both builds share one instantiation template
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_param_unused
  end
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    psel       = 1'b0;
    penable    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (handshake) state_next = SETUP;
      end
      SETUP: begin
        psel       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (bus.PREADY) begin
          state_next = handshake ? SETUP : IDLE;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      if (handshake) begin
        pwrite_reg <= bus.cmd_write;
        paddr_reg  <= bus.cmd_addr;
        pwdata_reg <= bus.cmd_wdata;
      end
      rsp_valid_reg <= complete || timeout_hit;
      if (complete) begin
        rsp_rdata_reg <= pwrite_reg ? '0 : bus.PRDATA;
        rsp_err_reg   <= bus.PSLVERR;
      end else if (timeout_hit) begin
        rsp_rdata_reg <= '0;
        rsp_err_reg   <= 1'b1;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.PSELx     = psel;
  assign bus.PENABLE   = penable;
  assign bus.PWRITE    = pwrite_reg;
  assign bus.PADDR     = paddr_reg;
  assign bus.PWDATA    = pwdata_reg;

endmodule

// File: tb/tb_apb_manager.sv
// Self-checking bench for apb_manager: directed cases plus randomized transfers
// against a transaction-level response model and an APB subordinate model.
module tb_apb_manager;

  localparam int TO = 4;
`ifdef APB_MGR_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  typedef struct {
    logic       w;
    logic [9:0] a;
    logic [7:0] d;
    int         waits;
    logic [7:0] prd;
    logic       err;
  } plan_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } rsp_t;

  logic PCLK;
  logic PRESET;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   mon_en = 1'b0;
  int   rsp_count = 0;

  logic [7:0] last_rdata = 8'h00;
  logic       last_err = 1'b0;

  plan_t plan_q[$];
  rsp_t  exp_q[$];

  apb_manager_if #(.ADDR_WIDTH(10), .DATA_WIDTH(8)) bus ();

  apb_manager #(
    .ADDR_WIDTH    (10),
    .DATA_WIDTH    (8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response of one transfer: handshake cycle + SETUP + ACCESS cycles, then the pulse
  function automatic rsp_t model(input plan_t p, input int hs);
    rsp_t r;
    if (TIMEOUT_ON && p.waits >= TO) begin
      r.rdata = 8'h00;
      r.err   = 1'b1;
      r.cyc   = hs + 2 + TO;
    end else begin
      r.rdata = p.w ? 8'h00 : p.prd;
      r.err   = p.err;
      r.cyc   = hs + 3 + p.waits;
    end
    return r;
  endfunction

  // Subordinate model: takes the next plan at SETUP, inserts its wait states in ACCESS
  plan_t cur;
  bit    cur_ok = 1'b0;
  int    wait_left = 0;
  always @(negedge PCLK) begin
    if (bus.PSELx === 1'b1 && bus.PENABLE === 1'b0) begin
      check("setup_planned", 32'(plan_q.size() > 0), 32'd1);
      cur_ok = plan_q.size() > 0;
      if (cur_ok) begin
        cur = plan_q.pop_front();
        wait_left = cur.waits;
        check("setup_paddr", 32'(bus.PADDR), 32'(cur.a));
        check("setup_pwrite", 32'(bus.PWRITE), 32'(cur.w));
        check("setup_pwdata", 32'(bus.PWDATA), 32'(cur.d));
      end
    end
    if (bus.PSELx === 1'b1 && bus.PENABLE === 1'b1 && cur_ok) begin
      check("access_paddr_stable", 32'(bus.PADDR), 32'(cur.a));
      check("access_pwdata_stable", 32'(bus.PWDATA), 32'(cur.d));
      if (wait_left > 0) begin
        wait_left--;
        bus.PREADY  = 1'b0;
        bus.PRDATA  = 8'($urandom);
        bus.PSLVERR = 1'($urandom);
      end else begin
        bus.PREADY  = 1'b1;
        bus.PRDATA  = cur.prd;
        bus.PSLVERR = cur.err;
      end
    end else begin
      bus.PREADY  = 1'($urandom);
      bus.PRDATA  = 8'($urandom);
      bus.PSLVERR = 1'($urandom);
    end
  end

  // Response monitor: every pulse must match the model, and outputs must hold in between
  always @(negedge PCLK) begin
    if (mon_en) begin
      check("penable_without_psel", 32'(bus.PENABLE & ~bus.PSELx), 32'd0);
      if (bus.rsp_valid === 1'b1) begin
        check("rsp_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          rsp_t e;
          e = exp_q.pop_front();
          check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
          check("rsp_err", 32'(bus.rsp_err), 32'(e.err));
          check("rsp_cycle", 32'(cyc), 32'(e.cyc));
          last_rdata = e.rdata;
          last_err   = e.err;
          rsp_count++;
          $display("rsp %0d: rdata=%02h err=%0b cycle=%0d", rsp_count, bus.rsp_rdata, bus.rsp_err, cyc);
        end
      end else begin
        check("rsp_valid_low", 32'(bus.rsp_valid), 32'd0);
        check("rsp_rdata_hold", 32'(bus.rsp_rdata), 32'(last_rdata));
        check("rsp_err_hold", 32'(bus.rsp_err), 32'(last_err));
      end
    end
  end

  task automatic send(input logic w, input logic [9:0] a, input logic [7:0] d, input int waits,
                      input logic [7:0] prd, input logic err, output int hs);
    plan_t p;
    int    guard;
    p.w = w; p.a = a; p.d = d; p.waits = waits; p.prd = prd; p.err = err;
    @(negedge PCLK); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = w;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    #1;
    guard = 0;
    while (bus.cmd_ready !== 1'b1 && guard < 50) begin
      @(negedge PCLK); #2;
      guard++;
    end
    check("accept_in_bound", 32'(guard < 50), 32'd1);
    hs = cyc;
    if (guard < 50) begin
      plan_q.push_back(p);
      exp_q.push_back(model(p, hs));
      @(posedge PCLK); #1;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'($urandom);
    bus.cmd_addr  = 10'($urandom);
    bus.cmd_wdata = 8'($urandom);
  endtask

  initial begin
    int hs1;
    int hs2;
    int guard;

    PRESET        = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;

    // Reset state
    repeat (2) @(posedge PCLK);
    #1;
    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    check("reset_psel", 32'(bus.PSELx), 32'd0);
    check("reset_penable", 32'(bus.PENABLE), 32'd0);
    check("reset_pwrite", 32'(bus.PWRITE), 32'd0);
    check("reset_paddr", 32'(bus.PADDR), 32'd0);
    check("reset_pwdata", 32'(bus.PWDATA), 32'd0);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    @(negedge PCLK); #1;
    PRESET = 1'b0;
    mon_en = 1'b1;

    // Zero-wait write: PSELx for two cycles, PENABLE in the second
    send(1'b1, 10'h055, 8'hA5, 0, 8'h00, 1'b0, hs1);
    @(negedge PCLK);
    check("wr_setup_psel", 32'(bus.PSELx), 32'd1);
    check("wr_setup_penable", 32'(bus.PENABLE), 32'd0);
    check("wr_pwdata", 32'(bus.PWDATA), 32'hA5);
    @(negedge PCLK);
    check("wr_access_psel", 32'(bus.PSELx), 32'd1);
    check("wr_access_penable", 32'(bus.PENABLE), 32'd1);
    @(negedge PCLK);
    check("wr_done_psel", 32'(bus.PSELx), 32'd0);

    // Read with two wait states: PENABLE held three cycles
    send(1'b0, 10'h3FF, 8'h00, 2, 8'h3C, 1'b0, hs1);
    @(negedge PCLK);
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("rd_wait_penable", 32'(bus.PENABLE), 32'd1);
      check("rd_wait_paddr", 32'(bus.PADDR), 32'h3FF);
    end
    @(negedge PCLK);
    check("rd_done_penable", 32'(bus.PENABLE), 32'd0);

    // Back-to-back writes: second handshake on the first transfer's completing cycle
    send(1'b1, 10'h101, 8'h11, 0, 8'h00, 1'b0, hs1);
    send(1'b1, 10'h202, 8'h22, 0, 8'h00, 1'b0, hs2);
    check("b2b_spacing", 32'(hs2 - hs1), 32'd2);
    @(negedge PCLK);
    check("b2b_psel_held", 32'(bus.PSELx), 32'd1);

    // Error read followed by a clean read
    send(1'b0, 10'h0F0, 8'h00, 1, 8'h5A, 1'b1, hs1);
    send(1'b0, 10'h0F1, 8'h00, 0, 8'hC3, 1'b0, hs1);
    repeat (4) @(negedge PCLK);

    // Reset in the middle of ACCESS: bus idles, response dropped
    send(1'b0, 10'h123, 8'h44, 6, 8'h99, 1'b0, hs1);
    @(negedge PCLK);
    @(negedge PCLK); #1;
    check("abort_in_access", 32'(bus.PENABLE), 32'd1);
    mon_en = 1'b0;
    PRESET = 1'b1;
    #1;
    check("abort_ready_in_reset", 32'(bus.cmd_ready), 32'd0);
    exp_q.delete();
    plan_q.delete();
    @(posedge PCLK); #1;
    check("abort_psel", 32'(bus.PSELx), 32'd0);
    check("abort_penable", 32'(bus.PENABLE), 32'd0);
    check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("abort_paddr", 32'(bus.PADDR), 32'd0);
    check("abort_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
    @(negedge PCLK); #1;
    PRESET     = 1'b0;
    last_rdata = 8'h00;
    last_err   = 1'b0;
    mon_en     = 1'b1;
    @(negedge PCLK);
    check("abort_no_rsp", 32'(bus.rsp_valid), 32'd0);

`ifdef APB_MGR_TIMEOUT_EN
    // Subordinate never ready: transfer abandoned after TO ACCESS cycles
    send(1'b0, 10'h2AA, 8'h11, 100, 8'h77, 1'b0, hs1);
    @(negedge PCLK);
    for (int i = 0; i < TO; i++) begin
      @(negedge PCLK);
      check("to_access_penable", 32'(bus.PENABLE), 32'd1);
    end
    @(negedge PCLK);
    check("to_psel_dropped", 32'(bus.PSELx), 32'd0);
    repeat (2) @(negedge PCLK);
`endif

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      int wt;
      wt = $urandom_range(0, TIMEOUT_ON ? 5 : 3);
      send(1'($urandom), 10'($urandom), 8'($urandom), wt, 8'($urandom),
           ($urandom_range(0, 3) == 0), hs1);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 3)) @(negedge PCLK);
    end

    guard = 0;
    while (exp_q.size() > 0 && guard < 100) begin
      @(negedge PCLK);
      guard++;
    end
    check("drain_complete", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge PCLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/apb_manager.md
APB_MANAGER -- requirements
Module: apb_manager

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, APB address width.
REQ-002 Parameter DATA_WIDTH, default 8, APB data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum ACCESS-phase wait cycles; used only with APB_MGR_TIMEOUT_EN.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 PCLK  input  1  sole clock; all logic on rising edge.
REQ-006 PRESET  input  1  synchronous, active-high reset.
REQ-007 cmd_valid  input  1  request present.
REQ-008 cmd_ready  output  1  request accepted when cmd_valid & cmd_ready.
REQ-009 cmd_write  input  1  1 = write, 0 = read.
REQ-010 cmd_addr  input  ADDR_WIDTH  transfer address.
REQ-011 cmd_wdata  input  DATA_WIDTH  write data.
REQ-012 rsp_valid  output  1  one-cycle completion pulse.
REQ-013 rsp_rdata  output  DATA_WIDTH  read data; 0 for writes.
REQ-014 rsp_err  output  1  captured PSLVERR, or timeout.
REQ-015 PSELx  output  1  subordinate select.
REQ-016 PENABLE  output  1  access phase.
REQ-017 PWRITE  output  1  transfer direction.
REQ-018 PADDR  output  ADDR_WIDTH  address.
REQ-019 PWDATA  output  DATA_WIDTH  write data.
REQ-020 PRDATA  input  DATA_WIDTH  read data from subordinate.
REQ-021 PREADY  input  1  subordinate ready; tie high for zero-wait subordinates.
REQ-022 PSLVERR  input  1  subordinate error.

Function
REQ-023 The FSM SHALL have states IDLE, SETUP and ACCESS.
- IDLE -> SETUP on handshake.
- SETUP -> ACCESS unconditionally.
- ACCESS -> ACCESS while PREADY=0.
- ACCESS with PREADY=1 -> SETUP if a handshake occurs in the same cycle, else IDLE.
REQ-024 cmd_ready SHALL be 1 in IDLE, and in ACCESS while PREADY=1; 0 otherwise.
REQ-025 Accepted cmd_write, cmd_addr and cmd_wdata SHALL be registered onto PWRITE, PADDR and PWDATA at the handshake edge.
REQ-026 PSELx SHALL be 1 in SETUP and ACCESS.
REQ-027 PENABLE SHALL be 1 only in ACCESS.
REQ-028 PADDR, PWRITE and PWDATA SHALL be stable from SETUP until ACCESS completes, and SHALL hold their last values in IDLE.
REQ-029 Completion:
- On the ACCESS cycle with PREADY=1, rsp_valid SHALL pulse for exactly one cycle on the next cycle.
- rsp_rdata SHALL carry captured PRDATA for reads and 0 for writes.
- rsp_err SHALL carry captured PSLVERR.
REQ-030 Minimum latency SHALL be 3 cycles, handshake to rsp_valid, with each wait state adding one cycle.
REQ-031 Back-to-back transfers SHALL sustain one transfer per 2 cycles with PREADY=1.
REQ-032 rsp_rdata and rsp_err SHALL hold their values until the next completion.
REQ-033 cmd_valid in SETUP, or in ACCESS with PREADY=0, SHALL be ignored (no handshake).

Reset
REQ-034 PRESET SHALL force the following on the next PCLK edge, overriding any in-flight transfer with no response generated:
- state IDLE;
- PSELx, PENABLE, PWRITE = 0; PADDR, PWDATA = 0;
- rsp_valid, rsp_err = 0; rsp_rdata = 0; timeout count = 0.
REQ-035 While PRESET is 1, cmd_ready SHALL be 0.

Configuration
REQ-036 With macro APB_MGR_TIMEOUT_EN defined:
- a counter SHALL count ACCESS cycles with PREADY=0;
- when the count reaches TIMEOUT_CYCLES, the transfer SHALL terminate: state IDLE, PSELx/PENABLE = 0, rsp_valid pulse with rsp_err=1 and rsp_rdata=0;
- the counter SHALL clear on each SETUP.
REQ-037 Without APB_MGR_TIMEOUT_EN, ACCESS SHALL wait indefinitely for PREADY, and no counter logic SHALL be synthesized.

Structure
REQ-038 Shared package apb_pkg SHALL hold:
- the apb_state_e enum (IDLE, SETUP, ACCESS);
- default ADDR_WIDTH/DATA_WIDTH constants;
- the default TIMEOUT_CYCLES constant.
REQ-039 The timeout counter SHALL be a sub-module apb_timeout_ctr, instantiated only under APB_MGR_TIMEOUT_EN; all other logic SHALL be flat.

Verification
REQ-040 Write addr 0x055, wdata 0xA5, PREADY=1 -> PSELx high 2 cycles, PENABLE in 2nd, PWDATA=0xA5, rsp_valid 3 cycles after handshake, rsp_err=0.
REQ-041 Read addr 0x3FF, PRDATA=0x3C, PREADY low 2 cycles -> PENABLE held 3 cycles, PADDR stable, rsp_rdata=0x3C after 5 cycles.
REQ-042 Two queued writes, cmd_valid held, PREADY=1 -> ACCESS->SETUP directly, PSELx never drops, 2 rsp_valid pulses 2 cycles apart.
REQ-043 Read with PSLVERR=1 at PREADY=1 -> rsp_err=1 for that response; next good transfer -> rsp_err=0.
REQ-044 PRESET asserted during ACCESS -> next cycle PSELx=PENABLE=0, state IDLE, no rsp_valid.
REQ-045 With APB_MGR_TIMEOUT_EN, TIMEOUT_CYCLES=4, PREADY=0 held -> PSELx drops after 4 ACCESS cycles, rsp_valid with rsp_err=1, rsp_rdata=0.
